dram_wb_pattern_master: RTL
===========================

// Module: dram_wb_pattern_master
// PURPOSE
//  Wishbone initiator driving the DRAM Wrapper's slave port (cyc/stb/we/addr/data/ack).
//  On start, waits for DRAM initialized, writes a deterministic pattern to NUM_WORDS
//  consecutive words, then reads them back and compares each word.
//  Reports pass/fail, error count and first failing word. Board-level DRAM bring-up and soak test.
// PARAMETERS
//  WORD_SIZE       256       data bus width, bits; multiple of 32
//  ADDR_WIDTH      25        word-index width; addr_o = {index, (32-ADDR_WIDTH)'0}
//  NUM_WORDS       1024      words tested per run; 1 <= NUM_WORDS <= 2**ADDR_WIDTH
//  TIMEOUT_CYCLES  4096      max cycles waiting for ack_i per transaction
//  SEED            32'hA5A5_0000  pattern seed
// PORTS
//  sys_clk            in   1           system clock (user clock domain of Wrapper)
//  rst                in   1           synchronous reset, active-high
//  start_i            in   1           one-cycle pulse: begin a run
//  initialized_i      in   1           DRAM calibration done, from Wrapper
//  cyc_o              out  1           Wishbone cycle
//  stb_o              out  1           Wishbone strobe
//  we_o               out  1           1 = write, 0 = read
//  addr_o             out  32          byte-style address, low (32-ADDR_WIDTH) bits zero
//  data_o             out  WORD_SIZE   write data
//  data_i             in   WORD_SIZE   read data, valid when ack_i = 1
//  ack_i              in   1           Wishbone acknowledge
//  busy_o             out  1           run in progress
//  done_o             out  1           run finished; held until next start_i or rst
//  pass_o             out  1           valid when done_o: no mismatches and no timeout
//  timeout_o          out  1           valid when done_o: run aborted on ack timeout
//  err_count_o        out  16          mismatching words, saturates at 16'hFFFF
//  first_err_idx_o    out  ADDR_WIDTH  index of first mismatching word; 0 if none
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; index 0; timeout counter 0.
//  - Pattern: lane k (bits 32k+31:32k) of word i = SEED ^ {k[7:0], i[23:0]}.
//  - Wishbone classic, single transfers: cyc_o = stb_o = 1, with we/addr/data stable,
//    held until the cycle ack_i = 1. Next edge drops cyc/stb for exactly one cycle before the next request.
//  - ack_i sampled only while stb_o = 1; stray ack_i otherwise ignored.
//  - FSM:
//    IDLE     -start_i->                   WAIT_INIT; clear done/pass/timeout/err_count/first_err_idx, index = 0
//    WAIT_INIT -initialized_i->            WR_REQ   (no bus activity while waiting)
//    WR_REQ   -ack_i->                     WR_GAP
//    WR_GAP   -index < NUM_WORDS-1->       WR_REQ, index++
//    WR_GAP   -index == NUM_WORDS-1->      RD_REQ, index = 0
//    RD_REQ   -ack_i->                     RD_GAP; compare data_i against pattern(index) in the ack cycle
//    RD_GAP   -index < NUM_WORDS-1->       RD_REQ, index++
//    RD_GAP   -last->                      DONE
//    DONE: done_o = 1; pass_o = (err_count == 0) & !timeout; start_i starts a new run
//  - Mismatch: err_count_o++ (saturating); on the first mismatch of a run, latch first_err_idx_o = index.
//  - Timeout: counter resets on each new request. If TIMEOUT_CYCLES elapse with no ack_i,
//    drop cyc/stb, timeout_o = 1, go to DONE with pass_o = 0.
//  - busy_o = 1 in every state except IDLE and DONE. start_i is ignored while busy_o = 1.
//  - NUM_WORDS = 1: one write, one read, then DONE.
//  - rst mid-transaction: cyc/stb low at the next edge; no completion is recorded.
//  - Write latency per word = ack latency + 1 gap cycle. Read compare is registered;
//    err_count_o updates 1 cycle after ack.
// STRUCTURE
//  - Shared package dram_wrapper_pkg: state enum pm_state_t; function pattern_word(idx, seed)
//    returning logic [WORD_SIZE-1:0]; constant WB_ADDR_W = 32.
//  - No sub-module. Timeout counter and comparator are inline.
//  - Top level wires the outputs to the Wrapper slave port and led[1:0] to {pass_o, done_o}.
// TESTING
//  1 Wishbone slave model with 2-cycle ack, NUM_WORDS=4, start_i ->
//    4 writes to addr 0x0, 0x80, 0x100, 0x180, then 4 reads; done_o=1, pass_o=1, err_count_o=0.
//  2 Slave model corrupts bit 0 of read word 2 -> err_count_o=1, first_err_idx_o=2, pass_o=0.
//  3 Slave never acks, TIMEOUT_CYCLES=16 -> cyc_o low after 16 cycles; timeout_o=1, done_o=1, pass_o=0.
//  4 initialized_i=0 for 100 cycles after start_i -> cyc_o stays 0 until initialized_i rises.
//  5 rst pulsed mid-read, then start_i again -> outputs 0 one edge after rst;
//    second run passes; start_i pulses while busy have no effect.
//  6 Assertion: stb_o -> cyc_o; addr/we/data stable while stb_o & !ack_i;
//    one idle cycle between consecutive requests.

Source files
------------

// File: rtl/dram_wrapper_pkg.sv
// Shared definitions for the DRAM wrapper pattern master.
//   pm_state_t   : pattern master FSM states
//   pattern_word : deterministic test word for a given word index and seed
//   WB_ADDR_W    : Wishbone byte-style address width
package dram_wrapper_pkg;

    localparam int WB_ADDR_W   = 32;
    // Widest data bus pattern_word can produce; callers size-cast down.
    localparam int PM_MAX_WORD = 1024;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INIT,
        WR_REQ,
        WR_GAP,
        RD_REQ,
        RD_GAP,
        DONE
    } pm_state_t;

    // Lane k of word idx = seed ^ {k[7:0], idx[23:0]}.
    function automatic logic [PM_MAX_WORD-1:0] pattern_word(input logic [31:0] idx,
                                                            input logic [31:0] seed);
        logic [PM_MAX_WORD-1:0] w;
        w = '0;
        for (int k = 0; k < PM_MAX_WORD / 32; k++) begin
            w[32*k +: 32] = seed ^ ({8'(k), 24'h0} | (idx & 32'h00FF_FFFF));
        end
        return w;
    endfunction

endpackage

// File: rtl/dram_wb_pattern_master.sv
// Wishbone classic initiator for DRAM bring-up / soak testing.
// On start_i it waits for initialized_i, writes a deterministic pattern to
// NUM_WORDS consecutive words, reads them back and compares each word.
//
// Ports
//   sys_clk, rst        clock, synchronous active-high reset
//   start_i             one-cycle pulse, starts a run when not busy
//   initialized_i       DRAM calibration done
//   cyc_o/stb_o/we_o    Wishbone control
//   addr_o              byte-style address {index, zeros}
//   data_o / data_i     write / read data
//   ack_i               Wishbone acknowledge (only honoured while stb_o = 1)
//   busy_o, done_o      run in progress / run finished (held)
//   pass_o, timeout_o   run result, valid with done_o
//   err_count_o         mismatching words (saturating)
//   first_err_idx_o     index of first mismatching word
module dram_wb_pattern_master
    import dram_wrapper_pkg::*;
#(
    parameter int          WORD_SIZE      = 256,
    parameter int          ADDR_WIDTH     = 25,
    parameter int          NUM_WORDS      = 1024,
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter logic [31:0] SEED           = 32'hA5A5_0000
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  initialized_i,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [WB_ADDR_W-1:0]  addr_o,
    output logic [WORD_SIZE-1:0]  data_o,
    input  logic [WORD_SIZE-1:0]  data_i,
    input  logic                  ack_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [15:0]           err_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_idx_o
);

    localparam int                    TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [TW-1:0]         TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    pm_state_t             state, next_state;
    logic [ADDR_WIDTH-1:0] index;
    logic [TW-1:0]         to_cnt;
    logic                  timeout_q;
    logic [15:0]           err_cnt;
    logic [ADDR_WIDTH-1:0] first_err;
    logic                  cmp_vld, cmp_miss;
    logic [ADDR_WIDTH-1:0] cmp_idx;

    logic                  req, acked, expired, last, start_fire;
    logic [WORD_SIZE-1:0]  pat;

    assign req        = (state == WR_REQ) || (state == RD_REQ);
    assign acked      = req && ack_i;
    // Last allowed wait cycle of this request passes without an ack.
    assign expired    = req && !ack_i && (to_cnt == TO_LAST);
    assign last       = (index == LAST_IDX);
    assign start_fire = ((state == IDLE) || (state == DONE)) && start_i;
    assign pat        = WORD_SIZE'(pattern_word(32'(index), SEED));

    always_ff @(posedge sys_clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:      if (start_i) next_state = WAIT_INIT;
            WAIT_INIT: if (initialized_i) next_state = WR_REQ;
            WR_REQ: begin
                if (acked)        next_state = WR_GAP;
                else if (expired) next_state = DONE;
            end
            WR_GAP:    next_state = last ? RD_REQ : WR_REQ;
            RD_REQ: begin
                if (acked)        next_state = RD_GAP;
                else if (expired) next_state = DONE;
            end
            RD_GAP:    next_state = last ? DONE : RD_REQ;
            DONE:      if (start_i) next_state = WAIT_INIT;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            index     <= '0;
            to_cnt    <= '0;
            timeout_q <= 1'b0;
            err_cnt   <= '0;
            first_err <= '0;
            cmp_vld   <= 1'b0;
            cmp_miss  <= 1'b0;
            cmp_idx   <= '0;
        end else begin
            cmp_vld <= 1'b0;

            if (start_fire) begin
                index     <= '0;
                timeout_q <= 1'b0;
                err_cnt   <= '0;
                first_err <= '0;
            end

            if (state == WR_GAP)           index <= last ? '0 : index + 1'b1;
            if (state == RD_GAP && !last)  index <= index + 1'b1;

            // Held at zero outside request states, so every request starts fresh.
            to_cnt <= (req && !ack_i) ? to_cnt + 1'b1 : '0;
            if (expired) timeout_q <= 1'b1;

            // Compare is registered; the error counters follow one cycle later.
            if (state == RD_REQ && ack_i) begin
                cmp_vld  <= 1'b1;
                cmp_miss <= (data_i != pat);
                cmp_idx  <= index;
            end

            if (cmp_vld && cmp_miss) begin
                if (err_cnt == '0)       first_err <= cmp_idx;
                if (err_cnt != 16'hFFFF) err_cnt   <= err_cnt + 16'd1;
            end
        end
    end

    assign cyc_o           = req;
    assign stb_o           = req;
    assign we_o            = (state == WR_REQ);
    assign addr_o          = req ? (WB_ADDR_W'(index) << (WB_ADDR_W - ADDR_WIDTH)) : '0;
    assign data_o          = (state == WR_REQ) ? pat : '0;
    assign busy_o          = (state != IDLE) && (state != DONE);
    assign done_o          = (state == DONE);
    assign pass_o          = done_o && (err_cnt == '0) && !timeout_q;
    assign timeout_o       = timeout_q;
    assign err_count_o     = err_cnt;
    assign first_err_idx_o = first_err;

endmodule
